// File: rtl/ht_pkg.sv
// ht_pkg - types, constants and helpers shared by the ht_sort_stream slice.
//   state_t : top-level frame sequencer states
//   ASC/DESC: sort direction encodings for the mode bit
//   pad()   : filler key that always sorts behind real keys for a direction
package ht_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SORT,
    DRAIN
  } state_t;

  localparam logic ASC  = 1'b0;
  localparam logic DESC = 1'b1;

  // Filler for unused slots: all-ones when ascending, all-zeros when
  // descending, so padding collects at the tail of the sorted array.
  // Returned 64 bits wide; callers cast it down to their key width.
  function automatic logic [63:0] pad(input logic m, input int w);
    logic [63:0] v;
    v = '0;
    if (m == ASC) begin
      for (int i = 0; i < 64; i++) begin
        if (i < w) v[i] = 1'b1;
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/ht_sort_stream_if.sv
// ht_sort_stream_if - bundles the key input stream, the sorted output stream
// and the frame status of ht_sort_stream.
//   master: the side feeding keys and consuming results (bench / system)
//   slave : the sorter itself
//   mode, in_valid/in_ready/in_data/in_last : input stream
//   out_valid/out_ready/out_data/out_last   : output stream
//   count, busy, done                       : frame status
interface ht_sort_stream_if #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 8,
  parameter int CNTW  = $clog2(DEPTH + 1)
);
  logic             mode;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic [CNTW-1:0]  count;
  logic             busy;
  logic             done;

  modport master (
    output mode, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, count, busy, done
  );

  modport slave (
    input  mode, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, count, busy, done
  );
endinterface

// File: rtl/ht_cmp_swap.sv
// ht_cmp_swap - combinational compare-exchange of two keys.
//   i_a, i_b : keys at the lower / upper position of the pair
//   i_mode   : ASC or DESC
//   o_lo     : key for the lower position, o_hi : key for the upper position
// Keys are exchanged only when strictly out of order, which keeps equal keys
// in their arrival order.
module ht_cmp_swap
  import ht_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_mode,
  output logic [WIDTH-1:0] o_lo,
  output logic [WIDTH-1:0] o_hi
);

  logic w_swap;

  assign w_swap = (i_mode == DESC) ? (i_a < i_b) : (i_a > i_b);
  assign o_lo   = w_swap ? i_b : i_a;
  assign o_hi   = w_swap ? i_a : i_b;

endmodule

// File: rtl/ht_sort_stream.sv
// ht_sort_stream - collects up to DEPTH keys from a valid/ready stream, sorts
// them with an odd-even transposition network and streams them back out.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : ht_sort_stream_if slave modport (streams plus count/busy/done)
module ht_sort_stream
  import ht_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int DEPTH = 8,
  parameter int CNTW  = $clog2(DEPTH + 1)
) (
  input logic              clk,
  input logic              rst_n,
  ht_sort_stream_if.slave  bus
);

  localparam int              IDXW    = $clog2(DEPTH);
  localparam int              NPAIR   = DEPTH / 2;
  localparam logic [CNTW-1:0] LASTCNT = CNTW'(DEPTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_slot [DEPTH];
  logic [WIDTH-1:0] w_next [DEPTH];
  logic             r_mode;
  logic [CNTW-1:0]  r_count;
  logic [CNTW-1:0]  r_rdIdx;
  logic [CNTW-1:0]  r_sortCnt;
  logic             r_phase;
  logic             r_inReady;
  logic             r_outValid;
  logic             r_outLast;
  logic [WIDTH-1:0] r_outData;
  logic             r_done;

  logic [WIDTH-1:0] w_pad;
  logic             w_inFire;
  logic [CNTW-1:0]  w_nextRd;
  logic [CNTW-1:0]  w_lastIdx;
  logic [WIDTH-1:0] w_a  [NPAIR];
  logic [WIDTH-1:0] w_b  [NPAIR];
  logic [WIDTH-1:0] w_lo [NPAIR];
  logic [WIDTH-1:0] w_hi [NPAIR];

  assign w_pad     = WIDTH'(pad(bus.mode, WIDTH));
  assign w_inFire  = bus.in_valid & r_inReady;
  assign w_nextRd  = r_rdIdx + CNTW'(1);
  assign w_lastIdx = r_count - CNTW'(1);

  // One comparator per pair; r_phase=0 pairs (2k,2k+1), r_phase=1 pairs
  // (2k+1,2k+2). With even DEPTH the last odd-phase pair has no partner, so
  // it compares a slot with itself and never swaps.
  for (genvar k = 0; k < NPAIR; k++) begin : gPair
    localparam int OB = (2 * k + 2 < DEPTH) ? 2 * k + 2 : 2 * k + 1;
    assign w_a[k] = r_phase ? r_slot[2*k+1] : r_slot[2*k];
    assign w_b[k] = r_phase ? r_slot[OB]    : r_slot[2*k+1];
    ht_cmp_swap #(.WIDTH(WIDTH)) uCmp (
      .i_a    (w_a[k]),
      .i_b    (w_b[k]),
      .i_mode (r_mode),
      .o_lo   (w_lo[k]),
      .o_hi   (w_hi[k])
    );
  end

  // Route comparator results back to slots; slots outside any pair in the
  // current layer keep their value.
  for (genvar j = 0; j < DEPTH; j++) begin : gSlot
    logic [WIDTH-1:0] w_ev;
    logic [WIDTH-1:0] w_od;
    if (j % 2 == 0) begin : gEvenSlot
      if (j + 1 < DEPTH) begin : gEvLo
        assign w_ev = w_lo[j/2];
      end else begin : gEvKeep
        assign w_ev = r_slot[j];
      end
      if (j == 0) begin : gOdKeep
        assign w_od = r_slot[0];
      end else begin : gOdHi
        assign w_od = w_hi[(j-2)/2];
      end
    end else begin : gOddSlot
      assign w_ev = w_hi[(j-1)/2];
      if (j + 1 < DEPTH) begin : gOdLo
        assign w_od = w_lo[(j-1)/2];
      end else begin : gOdKeep
        assign w_od = r_slot[j];
      end
    end
    assign w_next[j] = r_phase ? w_od : w_ev;
  end

  // Frame sequencer: load keys (padding the rest on the first beat), run
  // DEPTH network layers, then drain with registered output beats. The first
  // DRAIN cycle only loads the output register, which gives the DEPTH+1
  // latency from the last input beat to the first out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      for (int j = 0; j < DEPTH; j++) r_slot[j] <= '0;
      r_mode     <= ASC;
      r_count    <= '0;
      r_rdIdx    <= '0;
      r_sortCnt  <= '0;
      r_phase    <= 1'b0;
      r_inReady  <= 1'b0;
      r_outValid <= 1'b0;
      r_outLast  <= 1'b0;
      r_outData  <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          r_inReady <= 1'b1;
          if (w_inFire) begin
            r_mode <= bus.mode;
            for (int j = 0; j < DEPTH; j++) r_slot[j] <= w_pad;
            r_slot[0] <= bus.in_data;
            r_count   <= CNTW'(1);
            if (bus.in_last) begin
              r_state   <= SORT;
              r_inReady <= 1'b0;
              r_sortCnt <= '0;
              r_phase   <= 1'b0;
            end else begin
              r_state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (w_inFire) begin
            r_slot[r_count[IDXW-1:0]] <= bus.in_data;
            r_count <= r_count + CNTW'(1);
            if (bus.in_last || (r_count == LASTCNT)) begin
              r_state   <= SORT;
              r_inReady <= 1'b0;
              r_sortCnt <= '0;
              r_phase   <= 1'b0;
            end
          end
        end
        SORT: begin
          for (int j = 0; j < DEPTH; j++) r_slot[j] <= w_next[j];
          r_phase   <= ~r_phase;
          r_sortCnt <= r_sortCnt + CNTW'(1);
          if (r_sortCnt == LASTCNT) begin
            r_state <= DRAIN;
            r_rdIdx <= '0;
          end
        end
        DRAIN: begin
          if (!r_outValid) begin
            r_outValid <= 1'b1;
            r_outData  <= r_slot[r_rdIdx[IDXW-1:0]];
            r_outLast  <= (r_rdIdx == w_lastIdx);
          end else if (bus.out_ready) begin
            if (r_outLast) begin
              r_outValid <= 1'b0;
              r_outLast  <= 1'b0;
              r_done     <= 1'b1;
              r_count    <= '0;
              r_state    <= IDLE;
            end else begin
              r_rdIdx   <= w_nextRd;
              r_outData <= r_slot[w_nextRd[IDXW-1:0]];
              r_outLast <= (w_nextRd == w_lastIdx);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = r_inReady;
  assign bus.out_valid = r_outValid;
  assign bus.out_data  = r_outData;
  assign bus.out_last  = r_outLast;
  assign bus.count     = r_count;
  assign bus.busy      = (r_state != IDLE);
  assign bus.done      = r_done;

endmodule
